// File: rtl/ibex_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch queue and its aligner.
package ibex_fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        lo_err;
        logic        hi_err;
        logic        hi2_err;
    } fetch_word_t;

    localparam fetch_word_t FETCH_WORD_ZERO = '{
        rdata:   32'h0000_0000,
        err:     1'b0,
        lo_err:  1'b0,
        hi_err:  1'b0,
        hi2_err: 1'b0
    };

    // A half-word that errored is never treated as compressed.
    function automatic logic is_compressed(input logic [1:0] lsbs, input logic err);
        return (lsbs != 2'b11) & ~err;
    endfunction

endpackage

// File: rtl/ibex_fetch_align.sv
// Combinational aligner: turns the head word (and the following word when the
// PC is half-word aligned) into one instruction with its error and length flags.
module ibex_fetch_align
    import ibex_fetch_queue_pkg::*;
#(
    parameter bit AlignedOnly = 1'b0
) (
    input  fetch_word_t i_head,
    input  logic        i_head_valid,
    input  logic [15:0] i_next_rdata,
    input  logic        i_next_err,
    input  logic        i_next_lo_err,
    input  logic        i_next_valid,
    input  logic        i_pc1,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_err_plus2,
    output logic        o_len_err,
    output logic        o_compressed,
    output logic        o_pop_ok
);

    logic w_c_lo;
    logic w_c_hi;

    // Select aligned or unaligned view of the head and derive the flags.
    always_comb begin
        w_c_lo = is_compressed(i_head.rdata[1:0], i_head.err);
        w_c_hi = is_compressed(i_head.rdata[17:16], i_head.err);
        if (AlignedOnly || !i_pc1) begin
            o_valid      = i_head_valid;
            o_rdata      = i_head.rdata;
            o_err        = i_head.err;
            o_err_plus2  = 1'b0;
            o_len_err    = i_head.lo_err | (i_head.hi_err & ~w_c_lo)
                         | (AlignedOnly ? (i_head.hi2_err & ~w_c_lo & i_pc1) : 1'b0);
            o_compressed = w_c_lo;
            // A compressed instruction in the low half leaves the high half to consume.
            o_pop_ok     = AlignedOnly ? 1'b1 : ~w_c_lo;
        end else begin
            o_valid      = w_c_hi ? i_head_valid : i_next_valid;
            o_rdata      = {i_next_rdata, i_head.rdata[31:16]};
            o_err        = i_head.err | (~w_c_hi & i_next_err);
            o_err_plus2  = i_next_err & ~i_head.err;
            o_len_err    = i_head.hi_err | (~w_c_hi & i_next_lo_err);
            o_compressed = w_c_hi;
            o_pop_ok     = 1'b1;
        end
    end

endmodule

// File: rtl/ibex_fetch_queue.sv
// Instruction fetch queue: shift-register storage of fetch responses with a
// zero-latency bypass, PC tracking, fill level and sticky overflow.
module ibex_fetch_queue
    import ibex_fetch_queue_pkg::*;
#(
    parameter int unsigned NUM_REQS    = 2,
    parameter int unsigned SIDE_W      = 6,
    parameter bit          AlignedOnly = 1'b0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    output logic [NUM_REQS-1:0]             busy_o,
    output logic [$clog2(NUM_REQS+2)-1:0]   level_o,
    output logic                            overflow_o,
    input  logic                            in_valid_i,
    input  logic [31:0]                     in_addr_i,
    input  logic [31:0]                     in_rdata_i,
    input  logic                            in_err_i,
    input  logic [SIDE_W-1:0]               in_side_i,
    input  logic                            in_lo_err_i,
    input  logic                            in_hi_err_i,
    input  logic                            in_hi2_err_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            out_imm_o,
    output logic [31:0]                     out_addr_o,
    output logic [31:0]                     out_rdata_o,
    output logic                            out_err_o,
    output logic                            out_err_plus2_o,
    output logic [SIDE_W-1:0]               out_side_o,
    output logic                            out_len_err_o
);

    localparam int unsigned DEPTH = NUM_REQS + 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    fetch_word_t       r_data [DEPTH];
    logic [SIDE_W-1:0] r_side [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [30:0]       r_pc;
    logic              r_overflow;
    logic [LVL_W-1:0]  r_level;

    fetch_word_t       w_in;
    fetch_word_t       w_head;
    logic              w_head_valid;
    logic [15:0]       w_next_rdata;
    logic              w_next_err;
    logic              w_next_lo_err;
    logic              w_next_valid;
    logic              w_compressed;
    logic              w_pop_ok;
    logic              w_full;
    logic              w_push;
    logic              w_accept;
    logic              w_pop;
    logic [DEPTH-1:0]  w_lowest_free;
    logic [DEPTH-1:0]  w_valid_pushed;
    logic [DEPTH-1:0]  w_valid_next;
    fetch_word_t       w_data_pushed [DEPTH];
    fetch_word_t       w_data_next [DEPTH];
    logic [SIDE_W-1:0] w_side_pushed [DEPTH];
    logic [SIDE_W-1:0] w_side_next [DEPTH];
    logic [LVL_W-1:0]  w_level_next;
    logic [30:0]       w_pc_next;
    logic              w_overflow_next;
    logic              w_unused_addr0;

    assign w_unused_addr0 = in_addr_i[0];

    // Head is entry 0 when valid, otherwise the incoming response (bypass).
    always_comb begin
        w_in          = '{rdata: in_rdata_i, err: in_err_i, lo_err: in_lo_err_i,
                          hi_err: in_hi_err_i, hi2_err: in_hi2_err_i};
        w_head        = r_valid[0] ? r_data[0] : w_in;
        w_head_valid  = r_valid[0] | in_valid_i;
        w_next_rdata  = r_valid[1] ? r_data[1].rdata[15:0] : in_rdata_i[15:0];
        w_next_err    = r_valid[1] ? r_data[1].err : in_err_i;
        w_next_lo_err = r_valid[1] ? r_data[1].lo_err : in_lo_err_i;
        w_next_valid  = r_valid[1] | (r_valid[0] & in_valid_i);
        out_side_o    = r_valid[0] ? r_side[0] : in_side_i;
    end

    ibex_fetch_align #(
        .AlignedOnly (AlignedOnly)
    ) u_align (
        .i_head        (w_head),
        .i_head_valid  (w_head_valid),
        .i_next_rdata  (w_next_rdata),
        .i_next_err    (w_next_err),
        .i_next_lo_err (w_next_lo_err),
        .i_next_valid  (w_next_valid),
        .i_pc1         (r_pc[0]),
        .o_valid       (out_valid_o),
        .o_rdata       (out_rdata_o),
        .o_err         (out_err_o),
        .o_err_plus2   (out_err_plus2_o),
        .o_len_err     (out_len_err_o),
        .o_compressed  (w_compressed),
        .o_pop_ok      (w_pop_ok)
    );

    // Push into the lowest free slot first, then shift everything down on a pop.
    always_comb begin
        w_full         = &r_valid;
        w_accept       = out_valid_o & out_ready_i;
        w_pop          = w_accept & w_pop_ok;
        w_push         = in_valid_i & ~clear_i & ~w_full;
        w_lowest_free  = ~r_valid & (r_valid + DEPTH'(1'b1));
        w_valid_pushed = r_valid | (w_push ? w_lowest_free : {DEPTH{1'b0}});
        for (int i = 0; i < DEPTH; i++) begin
            w_data_pushed[i] = (w_push & w_lowest_free[i]) ? w_in : r_data[i];
            w_side_pushed[i] = (w_push & w_lowest_free[i]) ? in_side_i : r_side[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_data_next[i] = w_pop ? w_data_pushed[i+1] : w_data_pushed[i];
            w_side_next[i] = w_pop ? w_side_pushed[i+1] : w_side_pushed[i];
        end
        w_data_next[DEPTH-1] = w_data_pushed[DEPTH-1];
        w_side_next[DEPTH-1] = w_side_pushed[DEPTH-1];
        if (clear_i) begin
            w_valid_next    = {DEPTH{1'b0}};
            w_overflow_next = 1'b0;
        end else begin
            w_valid_next    = w_pop ? {1'b0, w_valid_pushed[DEPTH-1:1]} : w_valid_pushed;
            w_overflow_next = r_overflow | (in_valid_i & w_full);
        end
        w_level_next = {LVL_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_level_next = w_level_next + LVL_W'(w_valid_next[i]);
        end
    end

    // PC counts half-words; redirect wins over an accept in the same cycle.
    always_comb begin
        if (clear_i) begin
            w_pc_next = in_addr_i[31:1];
        end else if (w_accept) begin
            w_pc_next = r_pc + (w_compressed ? 31'd1 : 31'd2);
        end else begin
            w_pc_next = r_pc;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= {DEPTH{1'b0}};
            r_pc       <= 31'd0;
            r_overflow <= 1'b0;
            r_level    <= {LVL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= FETCH_WORD_ZERO;
                r_side[i] <= {SIDE_W{1'b0}};
            end
        end else begin
            r_valid    <= w_valid_next;
            r_pc       <= w_pc_next;
            r_overflow <= w_overflow_next;
            r_level    <= w_level_next;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_next[i];
                r_side[i] <= w_side_next[i];
            end
        end
    end

    assign busy_o     = r_valid[DEPTH-1:1];
    assign level_o    = r_level;
    assign overflow_o = r_overflow;
    assign out_imm_o  = ~r_valid[0];
    assign out_addr_o = {r_pc, 1'b0};

endmodule
